// File: rtl/fop_pkg.sv
// Shared definitions for the Fibonacci-or-prime (FOP) generator:
// FSM state encoding, membership masks and the set-selection helper.
package fop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit i set means value i belongs to the set.
  localparam logic [15:0] FIB_MASK   = 16'h212F;  // {0,1,2,3,5,8,13}
  localparam logic [15:0] PRIME_MASK = 16'h28AC;  // {2,3,5,7,11,13}
  localparam logic [15:0] FOP_MASK   = 16'h29AF;  // union of both

  localparam logic [3:0] LAST_MEMBER = 4'd13;

  // Set selection: 01 = Fibonacci only, 10 = prime only, 00/11 = union.
  function automatic logic [15:0] sel_mask(input logic [1:0] sel);
    case (sel)
      2'b01:   sel_mask = FIB_MASK;
      2'b10:   sel_mask = PRIME_MASK;
      default: sel_mask = FOP_MASK;
    endcase
  endfunction

endpackage

// File: rtl/fop_match.sv
// Combinational set-membership lookup: hit is the mask bit indexed by in.
module fop_match (
  input  logic [3:0]  in,
  input  logic [15:0] mask,
  output logic        hit
);

  assign hit = mask[in];

endmodule

// File: rtl/fop_gen.sv
// FOP sequence generator. Scans candidates upward from START_VAL and emits
// every member of the active set on a valid/ready output stream.
// Optional build macro: FOP_GEN_SEL_EN adds a sel[1:0] input choosing the
// Fibonacci, prime or union set; without it the union is always used.
module fop_gen
  import fop_pkg::*;
#(
  parameter int START_VAL = 0,
  parameter bit LOOP      = 1'b0,
  parameter int PASS_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              out_ready,
`ifdef FOP_GEN_SEL_EN
  input  logic [1:0]        sel,
`endif
  output logic [3:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  // Output handshake: a transfer happens on a rising edge where out_valid
  // and out_ready are both high. Once out_valid rises, out_data and
  // out_last stay fixed until that transfer (or until stop/reset withdraws
  // the word); out_ready has no effect while out_valid is low.

  state_t            state, state_n;
  logic [3:0]        cand, cand_n;
  logic [3:0]        data_n;
  logic              valid_n, last_n;
  logic [PASS_W-1:0] pass_n;
  logic              adv;
  logic              hit;
  logic [15:0]       mask;

`ifdef FOP_GEN_SEL_EN
  logic [1:0] sel_q;

  // Capture the set selection when a scan is launched; it holds all scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= 2'b00;
    end else if (state == IDLE && start && !stop) begin
      sel_q <= sel;
    end
  end

  assign mask = sel_mask(sel_q);
`else
  assign mask = FOP_MASK;
`endif

  fop_match u_match (
    .in   (cand),
    .mask (mask),
    .hit  (hit)
  );

  assign busy = (state == SCAN) || (state == HOLD);
  assign done = (state == DONE);

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = out_last;
    pass_n  = pass_cnt;
    adv     = 1'b0;
    if (stop) begin
      state_n = IDLE;
      valid_n = 1'b0;
      last_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cand_n  = 4'(START_VAL);
            pass_n  = '0;
            state_n = SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            data_n  = cand;
            valid_n = 1'b1;
            last_n  = (cand == LAST_MEMBER);
            state_n = HOLD;
          end else begin
            adv = 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            adv     = 1'b1;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      // Step to the next candidate, wrapping or finishing at 15.
      if (adv) begin
        if (cand != 4'd15) begin
          cand_n  = cand + 4'd1;
          state_n = SCAN;
        end else if (LOOP) begin
          cand_n  = 4'd0;
          pass_n  = pass_cnt + PASS_W'(1);
          state_n = SCAN;
        end else begin
          state_n = DONE;
        end
      end
    end
  end

  // State, candidate, output and pass-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'd0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      pass_cnt  <= pass_n;
    end
  end

endmodule

// File: tb/tb_fop_gen.sv
// Testbench for fop_gen: three instances (default, looping with a 2-bit
// pass counter, START_VAL=6), a cycle table for the basic scan, and
// hand-written sequences for backpressure, wrap, stop and reset cases.
module tb_fop_gen;

  logic clk = 1'b0;
  logic rst_n;

  // Clock generation.
  always #5 clk = ~clk;

  logic       a_start, a_stop, a_ready;
  logic [3:0] a_data;
  logic       a_valid, a_last, a_busy, a_done;
  logic [7:0] a_pass;

  logic       b_start, b_stop, b_ready;
  logic [3:0] b_data;
  logic       b_valid, b_last, b_busy, b_done;
  logic [1:0] b_pass;

  logic       c_start, c_stop, c_ready;
  logic [3:0] c_data;
  logic       c_valid, c_last, c_busy, c_done;
  logic [7:0] c_pass;

`ifdef FOP_GEN_SEL_EN
  logic [1:0] a_sel, b_sel, c_sel;
`endif

  fop_gen u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .out_ready(a_ready),
`ifdef FOP_GEN_SEL_EN
    .sel(a_sel),
`endif
    .out_data(a_data), .out_valid(a_valid), .out_last(a_last),
    .busy(a_busy), .done(a_done), .pass_cnt(a_pass)
  );

  fop_gen #(.LOOP(1'b1), .PASS_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .out_ready(b_ready),
`ifdef FOP_GEN_SEL_EN
    .sel(b_sel),
`endif
    .out_data(b_data), .out_valid(b_valid), .out_last(b_last),
    .busy(b_busy), .done(b_done), .pass_cnt(b_pass)
  );

  fop_gen #(.START_VAL(6)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .stop(c_stop), .out_ready(c_ready),
`ifdef FOP_GEN_SEL_EN
    .sel(c_sel),
`endif
    .out_data(c_data), .out_valid(c_valid), .out_last(c_last),
    .busy(c_busy), .done(c_done), .pass_cnt(c_pass)
  );

  int n_checks = 0;
  int n_errors = 0;

  int fop_list[9]   = '{0, 1, 2, 3, 5, 7, 8, 11, 13};
  int fib_list[7]   = '{0, 1, 2, 3, 5, 8, 13};
  int prime_list[6] = '{2, 3, 5, 7, 11, 13};

  // Expected words: {last, data} for a/c, {pass, last, data} for b.
  logic [4:0] exp_a_q[$];
  logic [6:0] exp_b_q[$];
  logic [4:0] exp_c_q[$];
  logic [4:0] ea, ec;
  logic [6:0] eb;

  typedef struct {
    logic       start;
    logic       v;
    logic [3:0] d;
    logic       l;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
  endtask

  function automatic logic [4:0] mk(input int v);
    logic [3:0] d;
    d = 4'(v);
    return {(v == 13), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tv(input int i, input logic s, input logic v, input int d,
                    input logic l, input logic bz, input logic dn);
    tbl[i].start = s;
    tbl[i].v     = v;
    tbl[i].d     = 4'(d);
    tbl[i].l     = l;
    tbl[i].busy  = bz;
    tbl[i].done  = dn;
  endtask

  // Scoreboards: compare each accepted word against the expected queue.
  always @(negedge clk) begin
    if (rst_n && a_valid && a_ready) begin
      if (exp_a_q.size() == 0) fail_now("a_extra_word", 32'(a_data));
      else begin
        ea = exp_a_q.pop_front();
        check("a_word", {27'd0, a_last, a_data}, {27'd0, ea});
      end
    end
    if (rst_n && b_valid && b_ready) begin
      if (exp_b_q.size() == 0) fail_now("b_extra_word", 32'(b_data));
      else begin
        eb = exp_b_q.pop_front();
        check("b_word", {25'd0, b_pass, b_last, b_data}, {25'd0, eb});
      end
    end
    if (rst_n && c_valid && c_ready) begin
      if (exp_c_q.size() == 0) fail_now("c_extra_word", 32'(c_data));
      else begin
        ec = exp_c_q.pop_front();
        check("c_word", {27'd0, c_last, c_data}, {27'd0, ec});
      end
    end
  end

  task automatic wait_a_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) fail_now(name, 32'(a_busy));
    tick();
  endtask

  task automatic wait_a_word(input int val, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_valid && a_data == 4'(val)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) fail_now(name, 32'(a_data));
  endtask

  task automatic push_a_fop();
    foreach (fop_list[i]) exp_a_q.push_back(mk(fop_list[i]));
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_data"}, 32'(a_data), 0);
    check({tag, "_valid"}, 32'(a_valid), 0);
    check({tag, "_last"}, 32'(a_last), 0);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_pass"}, 32'(a_pass), 0);
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // Global time limit so the run always ends on its own.
  initial begin
    #400000;
    fail_now("watchdog", 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    // Basic scan, ready held high: cycle-by-cycle expectations.
    tv(0, 1, 0, 0, 0, 1, 0);   tv(1, 0, 1, 0, 0, 1, 0);   tv(2, 0, 0, 0, 0, 1, 0);
    tv(3, 0, 1, 1, 0, 1, 0);   tv(4, 0, 0, 0, 0, 1, 0);   tv(5, 0, 1, 2, 0, 1, 0);
    tv(6, 0, 0, 0, 0, 1, 0);   tv(7, 0, 1, 3, 0, 1, 0);   tv(8, 0, 0, 0, 0, 1, 0);
    tv(9, 0, 0, 0, 0, 1, 0);   tv(10, 0, 1, 5, 0, 1, 0);  tv(11, 0, 0, 0, 0, 1, 0);
    tv(12, 0, 0, 0, 0, 1, 0);  tv(13, 0, 1, 7, 0, 1, 0);  tv(14, 0, 0, 0, 0, 1, 0);
    tv(15, 0, 1, 8, 0, 1, 0);  tv(16, 0, 0, 0, 0, 1, 0);  tv(17, 0, 0, 0, 0, 1, 0);
    tv(18, 0, 0, 0, 0, 1, 0);  tv(19, 0, 1, 11, 0, 1, 0); tv(20, 0, 0, 0, 0, 1, 0);
    tv(21, 0, 0, 0, 0, 1, 0);  tv(22, 0, 1, 13, 1, 1, 0); tv(23, 0, 0, 0, 0, 1, 0);
    tv(24, 0, 0, 0, 0, 1, 0);  tv(25, 0, 0, 0, 0, 0, 1);  tv(26, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0;
    c_start = 1'b0; c_stop = 1'b0; c_ready = 1'b0;
`ifdef FOP_GEN_SEL_EN
    a_sel = 2'b00; b_sel = 2'b00; c_sel = 2'b00;
`endif
    repeat (3) tick();
    check_a_reset("rst_a");
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_b_pass", 32'(b_pass), 0);
    check("rst_c_busy", 32'(c_busy), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven basic scan.
    push_a_fop();
    a_ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      a_start = tbl[i].start;
      tick();
      a_start = 1'b0;
      check($sformatf("t1_valid[%0d]", i), 32'(a_valid), 32'(tbl[i].v));
      check($sformatf("t1_last[%0d]", i), 32'(a_last), 32'(tbl[i].l));
      check($sformatf("t1_busy[%0d]", i), 32'(a_busy), 32'(tbl[i].busy));
      check($sformatf("t1_done[%0d]", i), 32'(a_done), 32'(tbl[i].done));
      if (tbl[i].v) check($sformatf("t1_data[%0d]", i), 32'(a_data), 32'(tbl[i].d));
    end
    check("t1_queue_empty", exp_a_q.size(), 0);

    // Backpressure on 5 for five cycles.
    push_a_fop();
    a_ready = 1'b1;
    start_a();
    wait_a_word(5, "t2_wait5");
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", 32'(a_valid), 1);
      check("t2_hold_data", 32'(a_data), 5);
    end
    a_ready = 1'b1;
    wait_a_done("t2_done_timeout");
    check("t2_queue_empty", exp_a_q.size(), 0);

    // Looping instance: five passes, pass_cnt wraps modulo 4.
    for (int p = 0; p < 5; p++)
      foreach (fop_list[i]) exp_b_q.push_back({2'(p % 4), mk(fop_list[i])});
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (exp_b_q.size() == 0) break;
      tick();
    end
    check("t3_queue_empty", exp_b_q.size(), 0);
    b_ready = 1'b0;
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    check("t3_stop_busy", 32'(b_busy), 0);
    check("t3_stop_valid", 32'(b_valid), 0);

    // START_VAL=6 and a start pulse in mid-scan.
    foreach (fop_list[i]) if (fop_list[i] >= 6) exp_c_q.push_back(mk(fop_list[i]));
    c_ready = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("t4_first_valid", 32'(c_valid), 0);
    repeat (5) tick();
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("t4_busy_mid", 32'(c_busy), 1);
    for (int i = 0; i < 200; i++) begin
      if (c_done) break;
      tick();
    end
    check("t4_done", 32'(c_done), 1);
    tick();
    check("t4_queue_empty", exp_c_q.size(), 0);

    // Stop while 7 is held, then restart from START_VAL.
    foreach (fop_list[i]) if (fop_list[i] < 7) exp_a_q.push_back(mk(fop_list[i]));
    a_ready = 1'b1;
    start_a();
    wait_a_word(7, "t5_wait7");
    a_ready = 1'b0;
    tick();
    check("t5_held_data", 32'(a_data), 7);
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    check("t5_stop_valid", 32'(a_valid), 0);
    check("t5_stop_busy", 32'(a_busy), 0);
    check("t5_stop_done", 32'(a_done), 0);
    check("t5_queue_after_stop", exp_a_q.size(), 0);
    a_start = 1'b1;
    a_stop = 1'b1;
    tick();
    a_start = 1'b0;
    a_stop = 1'b0;
    check("t5_stop_beats_start", 32'(a_busy), 0);
    push_a_fop();
    a_ready = 1'b1;
    start_a();
    wait_a_done("t5_restart_timeout");
    check("t5_restart_queue", exp_a_q.size(), 0);

`ifdef FOP_GEN_SEL_EN
    // Set selection: Fibonacci only, then prime only.
    foreach (fib_list[i]) exp_a_q.push_back(mk(fib_list[i]));
    a_sel = 2'b01;
    start_a();
    a_sel = 2'b10;
    wait_a_done("sel_fib_timeout");
    check("sel_fib_queue", exp_a_q.size(), 0);
    foreach (prime_list[i]) exp_a_q.push_back(mk(prime_list[i]));
    a_sel = 2'b10;
    start_a();
    a_sel = 2'b01;
    wait_a_done("sel_prime_timeout");
    check("sel_prime_queue", exp_a_q.size(), 0);
    a_sel = 2'b00;
`endif

    // Reset asserted while a word is held.
    a_ready = 1'b0;
    start_a();
    tick();
    check("t6_hold_valid", 32'(a_valid), 1);
    rst_n = 1'b0;
    tick();
    check_a_reset("t6_rst");
    rst_n = 1'b1;
    tick();
    check("t6_idle_after_reset", 32'(a_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
